// File: rtl/pattern_comparator_nlane_pkg.sv
// Shared types and constants for the N-lane mainband pattern comparator.
package ucie_pattern_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } e_cmp_states;

  localparam logic CMP_MODE_AGG     = 1'b0;
  localparam logic CMP_MODE_PERLANE = 1'b1;

endpackage

// File: rtl/pattern_comparator_nlane_if.sv
// Control, sample and result bundle between the pattern detector side and the comparator.
interface pattern_comparator_nlane_if #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_CNT_W = 12,
  parameter int AGG_CNT_W  = 16,
  parameter int BURST_W    = 16
) ();
  import ucie_pattern_cmp_pkg::*;

  // i_start is a level request: high in IDLE starts a test, low ends it (or aborts COMPARE).
  // i_valid qualifies one sample per cycle and is only honoured in COMPARE; o_done is the ack
  // and stays high with stable results until i_start drops. No backpressure exists.
  logic                  i_start;
  logic                  i_mode;
  logic [BURST_W-1:0]    i_burst_count;
  logic [NUM_LANES-1:0]  i_lane_mask;
  logic [LANE_CNT_W-1:0] i_thr_lane;
  logic [AGG_CNT_W-1:0]  i_thr_agg;
  logic                  i_valid;
  logic [NUM_LANES-1:0]  i_local_pattern;
  logic [NUM_LANES-1:0]  i_rx_pattern;
  logic [NUM_LANES-1:0]  o_per_lane_error;
  logic [AGG_CNT_W-1:0]  o_error_counter;
  logic                  o_done;
  logic                  o_busy;
  e_cmp_states           state;

  modport master (
    output i_start, i_mode, i_burst_count, i_lane_mask, i_thr_lane, i_thr_agg,
           i_valid, i_local_pattern, i_rx_pattern,
    input  o_per_lane_error, o_error_counter, o_done, o_busy, state
  );

  modport slave (
    input  i_start, i_mode, i_burst_count, i_lane_mask, i_thr_lane, i_thr_agg,
           i_valid, i_local_pattern, i_rx_pattern,
    output o_per_lane_error, o_error_counter, o_done, o_busy, state
  );
endinterface

// File: rtl/pattern_comparator_nlane_lane_error_counter.sv
// Per-lane saturating error counter with synchronous clear.
module lane_error_counter #(
  parameter int LANE_CNT_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  inc_en,
  output logic [LANE_CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc_en && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_comparator_nlane.sv
// Compares local vs received lane patterns over a programmed burst and reports per-lane or
// aggregate failure, with a lane mask and saturating counters.
module pattern_comparator_nlane
  import ucie_pattern_cmp_pkg::*;
#(
  parameter int NUM_LANES  = 16,
  parameter int LANE_CNT_W = 12,
  parameter int AGG_CNT_W  = 16,
  parameter int BURST_W    = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  pattern_comparator_nlane_if.slave bus
);

  e_cmp_states           state_q;
  logic                  mode_q;
  logic [BURST_W-1:0]    burst_q;
  logic [BURST_W-1:0]    sample_cnt;
  logic [NUM_LANES-1:0]  mask_q;
  logic [LANE_CNT_W-1:0] thr_lane_q;
  logic [AGG_CNT_W-1:0]  thr_agg_q;
  logic [AGG_CNT_W-1:0]  agg_cnt;
  logic [AGG_CNT_W-1:0]  agg_next;
  logic [NUM_LANES-1:0]  mism;
  logic [NUM_LANES-1:0]  lane_inc;
  logic [NUM_LANES-1:0]  lane_over;
  logic [LANE_CNT_W-1:0] lane_cnt [NUM_LANES];
  logic                  lane_clear;
  logic                  sample_take;
  logic                  last_sample;
  logic [NUM_LANES-1:0]  per_lane_q;
  logic [AGG_CNT_W-1:0]  err_cnt_q;
  logic                  done_q;
  logic                  busy_q;

  always_comb begin
    mism        = (bus.i_local_pattern ^ bus.i_rx_pattern) & mask_q;
    sample_take = (state_q == COMPARE) && bus.i_start && bus.i_valid && (burst_q != '0);
    lane_inc    = sample_take ? mism : '0;
    lane_clear  = (state_q == IDLE) && bus.i_start;
    last_sample = sample_take && ((sample_cnt + 1'b1) == burst_q);
    agg_next    = (sample_take && (|mism) && !(&agg_cnt)) ? agg_cnt + 1'b1 : agg_cnt;
    // Threshold test on the post-increment count so results are ready on the DONE entry edge.
    lane_over = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_over[i] = (lane_cnt[i] > thr_lane_q) ||
                     (lane_inc[i] && (lane_cnt[i] == thr_lane_q) && !(&lane_cnt[i]));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_error_counter #(.LANE_CNT_W(LANE_CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (lane_clear),
      .inc_en (lane_inc[g]),
      .count  (lane_cnt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= CMP_MODE_AGG;
      burst_q    <= '0;
      sample_cnt <= '0;
      mask_q     <= '0;
      thr_lane_q <= '0;
      thr_agg_q  <= '0;
      agg_cnt    <= '0;
      per_lane_q <= '0;
      err_cnt_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.i_start) begin
            mode_q     <= bus.i_mode;
            burst_q    <= bus.i_burst_count;
            mask_q     <= bus.i_lane_mask;
            thr_lane_q <= bus.i_thr_lane;
            thr_agg_q  <= bus.i_thr_agg;
            sample_cnt <= '0;
            agg_cnt    <= '0;
            per_lane_q <= '0;
            err_cnt_q  <= '0;
            busy_q     <= 1'b1;
            state_q    <= COMPARE;
          end
        end
        COMPARE: begin
          if (!bus.i_start) begin
            per_lane_q <= '0;
            err_cnt_q  <= '0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (burst_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (sample_take) begin
            sample_cnt <= sample_cnt + 1'b1;
            agg_cnt    <= agg_next;
            if (last_sample) begin
              err_cnt_q <= agg_next;
              if (mode_q == CMP_MODE_PERLANE) per_lane_q <= lane_over & mask_q;
              else per_lane_q <= (agg_next > thr_agg_q) ? mask_q : '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (!bus.i_start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_per_lane_error = per_lane_q;
  assign bus.o_error_counter  = err_cnt_q;
  assign bus.o_done           = done_q;
  assign bus.o_busy           = busy_q;
  assign bus.state            = state_q;

endmodule

// File: tb/tb_pattern_comparator_nlane.sv
// Self-checking bench for pattern_comparator_nlane: reference model feeds an expected queue.
module tb_pattern_comparator_nlane;
  import ucie_pattern_cmp_pkg::*;

  localparam int NL = 16;
  localparam int LW = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int LANE_MAX = (1 << LW) - 1;
  localparam int AGG_MAX  = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  logic [NL-1:0] exp_pl_q[$];
  logic [AW-1:0] exp_cnt_q[$];

  int            m_lane[NL];
  int            m_agg;
  logic          m_mode;
  logic [NL-1:0] m_mask;
  int            m_thr_lane;
  int            m_thr_agg;

  pattern_comparator_nlane_if #(.NUM_LANES(NL), .LANE_CNT_W(LW), .AGG_CNT_W(AW), .BURST_W(BW)) bus();

  pattern_comparator_nlane #(.NUM_LANES(NL), .LANE_CNT_W(LW), .AGG_CNT_W(AW), .BURST_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // driver tasks
  task automatic start_test(input logic mode, input int burst, input logic [NL-1:0] mask,
                            input int thr_lane, input int thr_agg);
    bus.i_mode        = mode;
    bus.i_burst_count = BW'(burst);
    bus.i_lane_mask   = mask;
    bus.i_thr_lane    = LW'(thr_lane);
    bus.i_thr_agg     = AW'(thr_agg);
    bus.i_valid       = 1'b0;
    bus.i_start       = 1'b1;
    m_mode = mode; m_mask = mask; m_thr_lane = thr_lane; m_thr_agg = thr_agg; m_agg = 0;
    foreach (m_lane[i]) m_lane[i] = 0;
    @(negedge clk);
  endtask

  task automatic scramble_config();
    bus.i_mode        = ~m_mode;
    bus.i_burst_count = BW'(3);
    bus.i_lane_mask   = '0;
    bus.i_thr_lane    = '1;
    bus.i_thr_agg     = '1;
  endtask

  task automatic send(input logic [NL-1:0] err, input bit gap);
    logic [NL-1:0] loc;
    logic [NL-1:0] mm;
    if (gap) begin
      loc = NL'($urandom);
      bus.i_valid = 1'b0; bus.i_local_pattern = loc; bus.i_rx_pattern = ~loc;
      @(negedge clk);
    end
    loc = NL'($urandom);
    bus.i_valid = 1'b1; bus.i_local_pattern = loc; bus.i_rx_pattern = loc ^ err;
    mm = err & m_mask;
    for (int i = 0; i < NL; i++) if (mm[i] && m_lane[i] < LANE_MAX) m_lane[i]++;
    if (|mm && m_agg < AGG_MAX) m_agg++;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  // scoreboard producer: expected results of the burst just driven
  task automatic push_expected();
    logic [NL-1:0] pl;
    pl = '0;
    if (m_mode == CMP_MODE_PERLANE) begin
      for (int i = 0; i < NL; i++) pl[i] = m_mask[i] && (m_lane[i] > m_thr_lane);
    end else if (m_agg > m_thr_agg) begin
      pl = m_mask;
    end
    exp_pl_q.push_back(pl);
    exp_cnt_q.push_back(AW'(m_agg));
  endtask

  task automatic test_reset();
    total++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_per_lane_error !== '0 ||
        bus.o_error_counter !== '0 || bus.state !== IDLE) begin
      bad++;
      $display("FAIL reset_values: done=%b busy=%b pl=%h cnt=%0d state=%0d, need all 0",
               bus.o_done, bus.o_busy, bus.o_per_lane_error, bus.o_error_counter, bus.state);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.state !== IDLE || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: state=%0d busy=%b, need IDLE/0", bus.state, bus.o_busy);
    end
  endtask

  task automatic test_perlane();
    logic [NL-1:0] err, pl;
    logic [AW-1:0] cnt;
    start_test(CMP_MODE_PERLANE, 100, 16'hFFFF, 2, 0);
    scramble_config();
    for (int s = 1; s <= 100; s++) begin
      err = '0;
      if (s == 10 || s == 20 || s == 30) err[5] = 1'b1;
      if (s == 40 || s == 50) err[9] = 1'b1;
      send(err, $urandom_range(0, 3) == 0);
      if (s == 50) begin
        total++;
        if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
          bad++; $display("FAIL perlane_busy_mid: busy=%b done=%b, need 1/0", bus.o_busy, bus.o_done);
        end
      end
    end
    push_expected();
    pl = exp_pl_q.pop_front(); cnt = exp_cnt_q.pop_front();
    total++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      bad++; $display("FAIL perlane_done_latency: done=%b busy=%b, need 1/0", bus.o_done, bus.o_busy);
    end
    total++;
    if (bus.o_per_lane_error !== pl) begin
      bad++; $display("FAIL perlane_result: got %h need %h", bus.o_per_lane_error, pl);
    end
    total++;
    if (bus.o_error_counter !== cnt) begin
      bad++; $display("FAIL perlane_counter: got %0d need %0d", bus.o_error_counter, cnt);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.o_done !== 1'b1 || bus.o_per_lane_error !== pl) begin
      bad++; $display("FAIL done_hold: done=%b pl=%h need 1/%h", bus.o_done, bus.o_per_lane_error, pl);
    end
    bus.i_start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.o_done !== 1'b0 || bus.state !== IDLE) begin
      bad++; $display("FAIL done_release: done=%b state=%0d need 0/IDLE", bus.o_done, bus.state);
    end
    total++;
    if (bus.o_per_lane_error !== pl || bus.o_error_counter !== cnt) begin
      bad++; $display("FAIL results_held: pl=%h cnt=%0d need %h/%0d", bus.o_per_lane_error,
                      bus.o_error_counter, pl, cnt);
    end
  endtask

  task automatic test_aggregate();
    logic [NL-1:0] err, pl;
    logic [AW-1:0] cnt;
    for (int run = 0; run < 2; run++) begin
      start_test(CMP_MODE_AGG, 40, 16'hFFFF, 0, 2);
      scramble_config();
      for (int s = 1; s <= 40; s++) begin
        err = '0;
        if (s == 10 || s == 20) err = 16'h000F;
        if (s == 30 && run == 0) err = 16'h0080;
        send(err, $urandom_range(0, 4) == 0);
      end
      push_expected();
      pl = exp_pl_q.pop_front(); cnt = exp_cnt_q.pop_front();
      total++;
      if (bus.o_done !== 1'b1 || bus.o_per_lane_error !== pl) begin
        bad++; $display("FAIL agg_result run%0d: done=%b pl=%h need 1/%h", run, bus.o_done,
                        bus.o_per_lane_error, pl);
      end
      total++;
      if (bus.o_error_counter !== cnt) begin
        bad++; $display("FAIL agg_counter run%0d: got %0d need %0d", run, bus.o_error_counter, cnt);
      end
      bus.i_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_mask();
    logic [NL-1:0] err, pl;
    logic [AW-1:0] cnt;
    start_test(CMP_MODE_PERLANE, 20, 16'h00FF, 0, 0);
    err = '0; err[12] = 1'b1;
    for (int s = 1; s <= 20; s++) send(err, $urandom_range(0, 3) == 0);
    push_expected();
    pl = exp_pl_q.pop_front(); cnt = exp_cnt_q.pop_front();
    total++;
    if (bus.o_done !== 1'b1 || bus.o_per_lane_error !== pl || bus.o_error_counter !== cnt) begin
      bad++; $display("FAIL mask_zero: done=%b pl=%h cnt=%0d need 1/%h/%0d", bus.o_done,
                      bus.o_per_lane_error, bus.o_error_counter, pl, cnt);
    end
    bus.i_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [NL-1:0] err, pl;
    logic [AW-1:0] cnt;
    for (int thr = 14; thr <= 15; thr++) begin
      start_test(CMP_MODE_PERLANE, 40, 16'hFFFF, thr, 0);
      err = 16'h0001;
      for (int s = 1; s <= 40; s++) send(err, 1'b0);
      push_expected();
      pl = exp_pl_q.pop_front(); cnt = exp_cnt_q.pop_front();
      total++;
      if (bus.o_done !== 1'b1 || bus.o_per_lane_error !== pl) begin
        bad++; $display("FAIL sat_thr%0d: done=%b pl=%h need 1/%h", thr, bus.o_done,
                        bus.o_per_lane_error, pl);
      end
      total++;
      if (bus.o_error_counter !== cnt) begin
        bad++; $display("FAIL sat_counter_thr%0d: got %0d need %0d", thr, bus.o_error_counter, cnt);
      end
      bus.i_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_abort_restart();
    logic [NL-1:0] err, pl;
    logic [AW-1:0] cnt;
    start_test(CMP_MODE_PERLANE, 100, 16'hFFFF, 1, 0);
    for (int s = 1; s <= 50; s++) send((s % 2 == 0) ? 16'h0008 : 16'h0000, 1'b0);
    bus.i_start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.state !== IDLE || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      bad++; $display("FAIL abort_idle: state=%0d busy=%b done=%b need IDLE/0/0", bus.state,
                      bus.o_busy, bus.o_done);
    end
    total++;
    if (bus.o_per_lane_error !== '0 || bus.o_error_counter !== '0) begin
      bad++; $display("FAIL abort_results: pl=%h cnt=%0d need 0/0", bus.o_per_lane_error,
                      bus.o_error_counter);
    end
    repeat (4) @(negedge clk);
    total++;
    if (bus.o_done !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: done=%b need 0", bus.o_done);
    end
    start_test(CMP_MODE_PERLANE, 30, 16'hFFFF, 1, 0);
    for (int s = 1; s <= 30; s++) begin
      err = (s == 5 || s == 15) ? 16'h0004 : 16'h0000;
      send(err, $urandom_range(0, 3) == 0);
    end
    push_expected();
    pl = exp_pl_q.pop_front(); cnt = exp_cnt_q.pop_front();
    total++;
    if (bus.o_done !== 1'b1 || bus.o_per_lane_error !== pl || bus.o_error_counter !== cnt) begin
      bad++; $display("FAIL restart_result: done=%b pl=%h cnt=%0d need 1/%h/%0d", bus.o_done,
                      bus.o_per_lane_error, bus.o_error_counter, pl, cnt);
    end
    bus.i_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst_zero();
    int waited;
    start_test(CMP_MODE_PERLANE, 0, 16'hFFFF, 0, 0);
    bus.i_valid = 1'b1;
    bus.i_local_pattern = 16'h0000;
    bus.i_rx_pattern = 16'hFFFF;
    waited = 0;
    while (bus.o_done !== 1'b1 && waited < 2) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (bus.o_done !== 1'b1) begin
      bad++; $display("FAIL burst0_done: done=%b after %0d cycles, need 1 within 2", bus.o_done, waited);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.o_per_lane_error !== '0 || bus.o_error_counter !== '0 || bus.o_done !== 1'b1) begin
      bad++; $display("FAIL burst0_results: pl=%h cnt=%0d done=%b need 0/0/1", bus.o_per_lane_error,
                      bus.o_error_counter, bus.o_done);
    end
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [NL-1:0] pl;
    logic [AW-1:0] cnt;
    start_test(CMP_MODE_PERLANE, 100, 16'hFFFF, 0, 0);
    for (int s = 1; s <= 10; s++) send(16'h0101, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.o_busy !== 1'b0 || bus.state !== IDLE || bus.o_done !== 1'b0) begin
      bad++; $display("FAIL reset_mid_compare: busy=%b state=%0d done=%b need 0/IDLE/0", bus.o_busy,
                      bus.state, bus.o_done);
    end
    bus.i_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_test(CMP_MODE_AGG, 5, 16'hFFFF, 0, 0);
    for (int s = 1; s <= 5; s++) send(16'h8000, 1'b0);
    push_expected();
    pl = exp_pl_q.pop_front(); cnt = exp_cnt_q.pop_front();
    total++;
    if (bus.o_done !== 1'b1 || bus.o_per_lane_error !== pl || bus.o_error_counter !== cnt) begin
      bad++; $display("FAIL pre_reset_done: done=%b pl=%h cnt=%0d need 1/%h/%0d", bus.o_done,
                      bus.o_per_lane_error, bus.o_error_counter, pl, cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.o_done !== 1'b0 || bus.o_per_lane_error !== '0 || bus.o_error_counter !== '0) begin
      bad++; $display("FAIL reset_in_done: done=%b pl=%h cnt=%0d need 0/0/0", bus.o_done,
                      bus.o_per_lane_error, bus.o_error_counter);
    end
    bus.i_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_mode = 1'b0; bus.i_burst_count = '0; bus.i_lane_mask = '0;
    bus.i_thr_lane = '0; bus.i_thr_agg = '0; bus.i_valid = 1'b0;
    bus.i_local_pattern = '0; bus.i_rx_pattern = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_perlane();
    test_aggregate();
    test_mask();
    test_saturation();
    test_abort_restart();
    test_burst_zero();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_comparator_nlane.md
Name: pattern_comparator_nlane

Overview:
Parametrised successor to the fixed 16-lane mainband pattern comparator used in the TX-initiated point test. It compares locally generated and received lane patterns for a programmed burst length, in per-lane or aggregate mode, with a per-lane mask and saturating counters. It sits between the pattern detector and tx_initiated_point_test_rx, which consumes o_per_lane_error as its comparison results and o_done as its comparison ack.

Parameters:
NUM_LANES, 16, number of compared lanes (1..64)
LANE_CNT_W, 12, per-lane error counter and threshold width
AGG_CNT_W, 16, aggregate error counter and threshold width
BURST_W, 16, width of the burst sample count

Ports:
clk  in  1  single clock for the whole block
rst_n  in  1  asynchronous active-low reset
i_start  in  1  level request; rising level in IDLE starts a test; deassertion ends or aborts it
i_mode  in  1  1 = per-lane mode, 0 = aggregate mode; latched at start
i_burst_count  in  BURST_W  number of valid samples to compare; latched at start
i_lane_mask  in  NUM_LANES  1 = lane participates; latched at start
i_thr_lane  in  LANE_CNT_W  per-lane error threshold; latched at start
i_thr_agg  in  AGG_CNT_W  aggregate error threshold; latched at start
i_valid  in  1  sample strobe from the buffer
i_local_pattern  in  NUM_LANES  locally generated bits, one per lane
i_rx_pattern  in  NUM_LANES  received bits, one per lane
o_per_lane_error  out  NUM_LANES  1 = lane failed
o_error_counter  out  AGG_CNT_W  aggregate error count
o_done  out  1  results valid
o_busy  out  1  comparison in progress

Behaviour:
- Reset: FSM goes to IDLE. All counters, latched config, o_per_lane_error, o_error_counter, o_done and o_busy are 0.
- FSM states: IDLE, COMPARE, DONE.
- IDLE to COMPARE when i_start=1:
  - Latch mode, burst count, mask and both thresholds.
  - Clear the lane counters, aggregate counter and sample counter.
  - Clear o_per_lane_error and o_error_counter.
  - o_busy=1 from the next cycle.
- COMPARE, each cycle with i_valid=1:
  - mism = (i_local_pattern ^ i_rx_pattern) & mask.
  - Lane counter i increments by 1 when mism[i]=1. Counters saturate at all-ones and never wrap.
  - The aggregate counter increments by 1 when |mism is true (one error per sample, not per lane), saturating at all-ones.
  - The sample counter increments. Samples with i_valid=0 are ignored.
- COMPARE to DONE on the cycle the accepted sample count reaches burst_count. That final sample is counted.
  - If burst_count=0: COMPARE to DONE on the first cycle with no samples, and all results are 0.
- Entry to DONE registers results in one cycle; o_done=1 and o_busy=0 from that cycle.
  - Per-lane mode: o_per_lane_error[i] = mask[i] & (lane_cnt[i] > thr_lane).
  - Aggregate mode: o_per_lane_error = mask when agg_cnt > thr_agg, else 0.
  - o_error_counter = agg_cnt in both modes.
- DONE holds o_done and results while i_start=1. When i_start=0: go to IDLE, o_done drops next cycle, results are held until the next start.
- Abort: i_start=0 during COMPARE returns to IDLE next cycle. o_done is not asserted and results are cleared to 0.
- i_valid during IDLE or DONE is ignored.
- Changes to config inputs after start have no effect until the next start.
- mask=0 gives a zero result in both modes. Counters still advance sample_cnt.
- Asynchronous reset mid-COMPARE returns everything to reset values immediately.

Decomposition:
- Package ucie_pattern_cmp_pkg:
  - e_cmp_states enum {IDLE, COMPARE, DONE} as logic [1:0].
  - Mode constants CMP_MODE_AGG=1'b0 and CMP_MODE_PERLANE=1'b1.
- Sub-module lane_error_counter (LANE_CNT_W parameter):
  - Inputs: clear, inc_en; output: saturating count.
  - Instantiated NUM_LANES times via generate.
- FSM, aggregate counter and sample counter live in the top.

Test Plan:
1. Per-lane, NUM_LANES=16, mask=FFFF, burst=100, thr_lane=2: lane 5 mismatches on 3 samples, lane 9 on 2 → o_per_lane_error=16'h0020, o_error_counter=5, o_done=1 one cycle after the 100th valid sample.
2. Aggregate, thr_agg=2: samples 10 and 20 each mismatch lanes 0..3, sample 30 mismatches lane 7 → o_error_counter=3, o_per_lane_error=16'hFFFF. Repeat with only two such samples → 16'h0000, counter 2.
3. Mask=16'h00FF with lane 12 mismatching on every sample, per-lane thr_lane=0 → o_per_lane_error=0, o_error_counter=0.
4. Saturation, LANE_CNT_W=4, burst=40, lane 0 always mismatching, thr_lane=14 → lane counter holds 15 with no wrap, o_per_lane_error[0]=1.
5. Abort: drop i_start after 50 of 100 samples → o_done never asserts, results 0, IDLE next cycle. Restart → a clean test gives correct results.
6. burst=0 → o_done within 2 cycles of start with zero results. Assert rst_n=0 mid-COMPARE → all outputs 0 immediately.
